sinc3_dec_mc: RTL and testbench
===============================

SINC3_DEC_MC -- requirements
Module: sinc3_dec_mc

Interface
REQ-001 Parameter NCH, default 4, number of modulator channels (1..16).
REQ-002 Parameter ACC_W, default 37, integrator/comb width in bits (supports R up to 4096, sinc3).
REQ-003 Parameter OUT_W, fixed 16, output word width.
REQ-004 mclk1  input  1  modulator bit clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mdata  input  NCH  one modulator bitstream per channel, sampled on rising mclk1.
REQ-007 enable  input  1  run request; low = idle/flush.
REQ-008 dec_sel  input  3  decimation rate R = 2^(dec_sel+5) (0=32 .. 7=4096).
REQ-009 signed_mode  input  1  0 = unipolar (bit 0 -> 0), 1 = bipolar (bit 0 -> -1, 1 -> +1).
REQ-010 data_out  output  16  filtered word for channel data_ch.
REQ-011 data_ch  output  max(1,clog2(NCH))  channel index of data_out.
REQ-012 data_valid  output  1  one-cycle strobe qualifying data_out/data_ch.
REQ-013 busy  output  1  high in SETTLE and RUN.

Function
REQ-014 Single clock domain; no derived clocks; decimation by clock enable only.
REQ-015 FSM states IDLE, SETTLE, RUN; IDLE->SETTLE on enable=1; SETTLE->RUN after 3 discarded decimation ticks; any state->IDLE on enable=0 (same cycle as enable sampled low).
REQ-016 dec_sel and signed_mode latched only on IDLE->SETTLE transition; changes at other times ignored.
REQ-017 In IDLE: integrators, comb delays, decimation counter held at 0; data_valid=0.
REQ-018 Per channel, three cascaded integrators each cycle in SETTLE/RUN, ACC_W bits, two's-complement wrap-around (modular arithmetic, no saturation).
REQ-019 Decimation counter counts 0..R-1 and wraps; tick asserted in cycle counter==R-1.
REQ-020 On tick, acc3 of all channels snapshotted in the same cycle.
REQ-021 Comb (three differentiators, one delay each per channel) time-multiplexed: one channel per cycle, ascending index, starting cycle after tick.
REQ-022 Channel c result: data_valid high in cycle T+2+c (T = tick cycle), data_ch=c; NCH consecutive strobes per tick.
REQ-023 Comb delay registers update on every tick in SETTLE and RUN; data_valid suppressed in SETTLE.
REQ-024 Unipolar scaling, k=dec_sel+5: value 2^(3k) -> 16'hFFFF; otherwise data_out = diff3 bits [3k-1:3k-16] (k=5: {diff3[14:0],1'b0}).
REQ-025 Bipolar scaling: data_out = diff3 arithmetic-shifted right by 3k-15 (k=5: no shift), saturated to 16'h7FFF / 16'h8000.
REQ-026 data_out, data_ch hold last value between strobes.
REQ-027 Min R (32) >= NCH+2, so comb sequence always completes before next tick; no overrun path required.
REQ-028 enable falling mid-comb-sequence: remaining strobes of that sequence suppressed.

Reset
REQ-029 On reset: FSM=IDLE, all accumulators/comb/counter=0, data_out=0, data_ch=0, data_valid=0, busy=0, latched config dec_sel=0, signed_mode=0.
REQ-030 Reset asserted mid-operation takes effect immediately; after release, operation resumes only via new IDLE->SETTLE.

Structure
REQ-031 Shared package sinc_pkg: FSM state enum, dec_sel-to-shift function, saturation constants 16'hFFFF/16'h7FFF/16'h8000.
REQ-032 Sub-module sinc3_integ (one channel, three integrators, input mapping) instantiated NCH times; comb and FSM in top.

Verification
REQ-033 NCH=4, R=256 unipolar, all mdata=1 -> after settle, each channel data_out=16'hFFFF, strobes at T+2..T+5.
REQ-034 R=256 unipolar, all mdata=0 -> data_out=16'h0000 all channels.
REQ-035 R=32 bipolar, ch0 all 1s, ch1 all 0s, ch2/ch3 alternating 1010 -> ch0=16'h7FFF, ch1=16'h8000, ch2/ch3=16'h0000 (+/-1 LSB).
REQ-036 enable rise -> first data_valid exactly after 4th tick (3 discarded); dec_sel changed during RUN -> R unchanged until enable toggled.
REQ-037 Reset asserted at cycle T+3 of a comb sequence -> data_valid low immediately, all outputs 0, no further strobes until re-enable plus settle.
REQ-038 R=4096 unipolar, 50% density stream -> data_out=16'h8000 +/-1 LSB, verifying 37-bit wrap-around correctness.

Source files
------------

// File: rtl/sinc_pkg.sv
// Shared types and constants for the multi-channel sinc3 decimator:
// FSM state encoding, decimation-rate decode and output saturation words.
package sinc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN
  } state_t;

  localparam int          OUT_W        = 16;
  localparam int          SETTLE_TICKS = 3;
  localparam logic [15:0] SAT_UNI_MAX  = 16'hFFFF;
  localparam logic [15:0] SAT_BIP_MAX  = 16'h7FFF;
  localparam logic [15:0] SAT_BIP_MIN  = 16'h8000;

  // log2 of the decimation rate: R = 2^(dec_sel+5)
  function automatic logic [3:0] dec_shift(input logic [2:0] sel);
    return 4'(sel) + 4'd5;
  endfunction

endpackage

// File: rtl/sinc3_dec_mc_if.sv
// Bundle of the decimator's run controls, modulator inputs and result outputs.
// The master side drives the inputs; the decimator attaches to the slave side.
interface sinc3_dec_mc_if #(
  parameter int NCH = 4
);
  import sinc_pkg::*;

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   mdata;
  logic             enable;
  logic [2:0]       dec_sel;
  logic             signed_mode;
  logic [OUT_W-1:0] data_out;
  logic [CH_W-1:0]  data_ch;
  logic             data_valid;
  logic             busy;

  modport master (
    output mdata, enable, dec_sel, signed_mode,
    input  data_out, data_ch, data_valid, busy
  );

  modport slave (
    input  mdata, enable, dec_sel, signed_mode,
    output data_out, data_ch, data_valid, busy
  );

endinterface

// File: rtl/sinc3_integ.sv
// One channel of the sinc3 front end: bit-to-sample mapping followed by
// three cascaded wrap-around integrators running at the modulator rate.
module sinc3_integ
  import sinc_pkg::*;
#(
  parameter int ACC_W = 37
) (
  input  logic             mclk1,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_bit,
  input  logic             i_signed,
  output logic [ACC_W-1:0] o_acc3
);

  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] r_acc1;
  logic [ACC_W-1:0] r_acc2;
  logic [ACC_W-1:0] r_acc3;

  // Unipolar maps a 0 bit to 0; bipolar maps it to -1 (all ones).
  always_comb begin
    w_x = '0;
    if (i_bit)         w_x = ACC_W'(1);
    else if (i_signed) w_x = '1;
  end

  // NOTE: state registers use non-blocking assignments so each stage sees the
  // previous stage's value from before this edge, giving a true cascade.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_acc3 <= '0;
    end else if (!i_run) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_acc3 <= '0;
    end else begin
      r_acc1 <= r_acc1 + w_x;
      r_acc2 <= r_acc2 + r_acc1;
      r_acc3 <= r_acc3 + r_acc2;
    end
  end

  assign o_acc3 = r_acc3;

endmodule

// File: rtl/sinc3_dec_mc.sv
// Multi-channel sinc3 decimator: per-channel integrators, a shared comb that
// walks the channels one per cycle after each decimation tick, and the run FSM.
module sinc3_dec_mc
  import sinc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int ACC_W = 37,
  parameter int OUT_W = 16
) (
  input  logic           mclk1,
  input  logic           reset,
  sinc3_dec_mc_if.slave  bus
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [ACC_W-1:0] BIP_HI = signed'(ACC_W'(32'sd32767));
  localparam logic signed [ACC_W-1:0] BIP_LO = signed'(ACC_W'(-32'sd32768));

  state_t           r_state;
  logic [2:0]       r_dec_sel;
  logic             r_signed;
  logic [11:0]      r_cnt;
  logic [1:0]       r_settle_cnt;

  logic             w_run;
  logic             w_tick;
  logic [11:0]      w_cnt_max;
  logic [5:0]       w_sh3;
  logic [5:0]       w_shr;

  logic [ACC_W-1:0] w_acc3 [NCH];
  logic [ACC_W-1:0] r_snap [NCH];
  logic [ACC_W-1:0] r_z1   [NCH];
  logic [ACC_W-1:0] r_z2   [NCH];
  logic [ACC_W-1:0] r_z3   [NCH];

  logic             r_comb_act;
  logic             r_comb_emit;
  logic [CH_W-1:0]  r_comb_idx;
  logic [ACC_W-1:0] w_d1;
  logic [ACC_W-1:0] w_d2;
  logic [ACC_W-1:0] w_d3;
  logic signed [ACC_W-1:0] w_bip;
  logic [OUT_W-1:0] w_word;

  logic [OUT_W-1:0] r_data_out;
  logic [CH_W-1:0]  r_data_ch;
  logic             r_data_valid;

  // Dropping enable stops everything on the very edge it is sampled low.
  assign w_run     = (r_state != ST_IDLE) && bus.enable;
  assign w_cnt_max = 12'((13'd1 << dec_shift(r_dec_sel)) - 13'd1);
  assign w_tick    = w_run && (r_cnt == w_cnt_max);
  assign w_sh3     = 6'(dec_shift(r_dec_sel)) * 6'd3;
  assign w_shr     = w_sh3 - 6'd15;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sinc3_integ #(.ACC_W(ACC_W)) u_integ (
      .mclk1    (mclk1),
      .reset    (reset),
      .i_run    (w_run),
      .i_bit    (bus.mdata[g]),
      .i_signed (r_signed),
      .o_acc3   (w_acc3[g])
    );
  end

  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dec_sel    <= '0;
      r_signed     <= 1'b0;
      r_cnt        <= '0;
      r_settle_cnt <= '0;
    end else if (!bus.enable) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_SETTLE;
          r_dec_sel    <= bus.dec_sel;
          r_signed     <= bus.signed_mode;
          r_cnt        <= '0;
          r_settle_cnt <= '0;
        end
        ST_SETTLE: begin
          r_cnt <= w_tick ? 12'd0 : r_cnt + 12'd1;
          if (w_tick) begin
            if (r_settle_cnt == 2'(SETTLE_TICKS - 1)) begin
              r_state      <= ST_RUN;
              r_settle_cnt <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + 2'd1;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= w_tick ? 12'd0 : r_cnt + 12'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Three differentiators for the channel currently selected by the sequencer.
  always_comb begin
    w_d1 = r_snap[r_comb_idx] - r_z1[r_comb_idx];
    w_d2 = w_d1 - r_z2[r_comb_idx];
    w_d3 = w_d2 - r_z3[r_comb_idx];
  end

  // Full scale is exactly 2^(3k); unipolar keeps 16 bits below that,
  // bipolar shifts to a +/-2^15 range and saturates.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so no path can leave it unassigned and infer a latch.
    w_word = '0;
    w_bip  = $signed(w_d3) >>> w_shr;
    if (!r_signed) begin
      if (w_d3 == (ACC_W'(1) << w_sh3)) w_word = OUT_W'(SAT_UNI_MAX);
      else                              w_word = OUT_W'({w_d3, 1'b0} >> w_shr);
    end else begin
      if (w_bip > BIP_HI)      w_word = OUT_W'(SAT_BIP_MAX);
      else if (w_bip < BIP_LO) w_word = OUT_W'(SAT_BIP_MIN);
      else                     w_word = OUT_W'(w_bip);
    end
  end

  // NOTE: the per-channel snapshot and comb delay arrays are explicitly reset
  // because idle must hold them at zero; they are registers, not RAM.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        r_snap[c] <= '0;
        r_z1[c]   <= '0;
        r_z2[c]   <= '0;
        r_z3[c]   <= '0;
      end
      r_comb_act   <= 1'b0;
      r_comb_emit  <= 1'b0;
      r_comb_idx   <= '0;
      r_data_out   <= '0;
      r_data_ch    <= '0;
      r_data_valid <= 1'b0;
    end else if (!w_run) begin
      for (int c = 0; c < NCH; c++) begin
        r_snap[c] <= '0;
        r_z1[c]   <= '0;
        r_z2[c]   <= '0;
        r_z3[c]   <= '0;
      end
      r_comb_act   <= 1'b0;
      r_comb_emit  <= 1'b0;
      r_comb_idx   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_tick) begin
        for (int c = 0; c < NCH; c++) r_snap[c] <= w_acc3[c];
        r_comb_act  <= 1'b1;
        r_comb_idx  <= '0;
        r_comb_emit <= (r_state == ST_RUN);
      end else if (r_comb_act) begin
        r_z1[r_comb_idx] <= r_snap[r_comb_idx];
        r_z2[r_comb_idx] <= w_d1;
        r_z3[r_comb_idx] <= w_d2;
        if (r_comb_emit) begin
          r_data_out   <= w_word;
          r_data_ch    <= r_comb_idx;
          r_data_valid <= 1'b1;
        end
        if (r_comb_idx == CH_W'(NCH - 1)) r_comb_act <= 1'b0;
        else                              r_comb_idx <= r_comb_idx + CH_W'(1);
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_ch    = r_data_ch;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sinc3_dec_mc.sv
// Scoreboard bench for sinc3_dec_mc: each run pushes the expected word, channel
// and strobe cycle of every result; a negedge monitor pops and compares them.
module tb_sinc3_dec_mc;

  localparam int NCH = 4;

  typedef struct {
    logic [15:0] data;
    int          ch;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  int   mode [NCH];   // 0 = all zeros, 1 = all ones, 2 = alternating
  logic alt_ph;

  sinc3_dec_mc_if #(.NCH(NCH)) bus ();

  sinc3_dec_mc #(.NCH(NCH), .ACC_W(37), .OUT_W(16)) dut (
    .mclk1 (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected filtered word from the stream pattern and mode alone.
  function automatic logic [15:0] exp_val(input int m, input logic sgn);
    if (!sgn) return (m == 1) ? 16'hFFFF : (m == 0) ? 16'h0000 : 16'h8000;
    else      return (m == 1) ? 16'h7FFF : (m == 0) ? 16'h8000 : 16'h0000;
  endfunction

  initial begin
    bus.mdata = '0;
    alt_ph    = 1'b0;
    forever begin
      @(negedge clk);
      alt_ph = ~alt_ph;
      for (int c = 0; c < NCH; c++)
        bus.mdata[c] = (mode[c] == 1) ? 1'b1 : (mode[c] == 0) ? 1'b0 : alt_ph;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.data_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", bus.data_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("data_out", bus.data_out, e.data);
        check("data_ch", bus.data_ch, e.ch);
        check("strobe_cyc", cyc, e.cyc);
      end
    end
  end

  // Enable the filter and queue the results of nseq sequences; the last one
  // is truncated to nlast channels.
  task automatic start_run(input logic [2:0] sel, input logic sgn, input int nseq, input int nlast);
    int e;
    int r;
    exp_t x;
    @(negedge clk);
    bus.dec_sel     = sel;
    bus.signed_mode = sgn;
    bus.enable      = 1'b1;
    e = cyc + 1;
    r = 1 << (int'(sel) + 5);
    for (int s = 0; s < nseq; s++)
      for (int c = 0; c < NCH; c++)
        if (s < nseq - 1 || c < nlast) begin
          x.data = exp_val(mode[c], sgn);
          x.ch   = c;
          x.cyc  = e + (4 + s) * r + 1 + c;
          sb.push_back(x);
        end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic stop_run();
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    check("busy_off", bus.busy, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc             = 0;
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.dec_sel     = 3'd0;
    bus.signed_mode = 1'b0;
    for (int c = 0; c < NCH; c++) mode[c] = 0;
    idle(3);
    rst = 1'b0;
    idle(2);
    check("rst_data_out", bus.data_out, 16'h0000);
    check("rst_data_ch", bus.data_ch, 0);
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);

    // R=256 unipolar, constant ones: full scale on every channel.
    for (int c = 0; c < NCH; c++) mode[c] = 1;
    start_run(3'd3, 1'b0, 2, NCH);
    @(posedge clk);
    #1;
    check("busy_on", bus.busy, 1'b1);
    wait_drain("drain_uni_ones", 7000);
    stop_run();

    // R=256 unipolar, constant zeros.
    for (int c = 0; c < NCH; c++) mode[c] = 0;
    start_run(3'd3, 1'b0, 1, NCH);
    wait_drain("drain_uni_zeros", 7000);
    stop_run();

    // R=32 bipolar: +full scale, -full scale, two mid-scale channels.
    mode[0] = 1; mode[1] = 0; mode[2] = 2; mode[3] = 2;
    start_run(3'd0, 1'b1, 2, NCH);
    wait_drain("drain_bipolar", 1000);
    stop_run();

    // Config changes while running must not alter rate or mode.
    for (int c = 0; c < NCH; c++) mode[c] = 1;
    start_run(3'd0, 1'b0, 2, NCH);
    idle(10);
    bus.dec_sel     = 3'd7;
    bus.signed_mode = 1'b1;
    wait_drain("drain_cfg_hold", 1000);
    stop_run();

    // Enable drops after ch1 of a sequence: later strobes vanish, outputs hold.
    start_run(3'd0, 1'b0, 1, 2);
    wait_drain("drain_partial", 1000);
    bus.enable = 1'b0;
    idle(96);
    check("hold_data_out", bus.data_out, 16'hFFFF);
    check("hold_data_ch", bus.data_ch, 1);
    check("hold_valid", bus.data_valid, 1'b0);

    // Reset lands while ch1's strobe is up.
    start_run(3'd0, 1'b0, 1, 1);
    wait_drain("drain_pre_reset", 1000);
    @(posedge clk);
    #1;
    check("pre_reset_valid", bus.data_valid, 1'b1);
    rst        = 1'b1;
    bus.enable = 1'b0;
    #1;
    check("mid_rst_valid", bus.data_valid, 1'b0);
    check("mid_rst_data_out", bus.data_out, 16'h0000);
    check("mid_rst_data_ch", bus.data_ch, 0);
    check("mid_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(160);
    check("post_rst_busy", bus.busy, 1'b0);

    // R=4096 unipolar, 50% density: exercises accumulator wrap-around.
    for (int c = 0; c < NCH; c++) mode[c] = 2;
    start_run(3'd7, 1'b0, 1, NCH);
    wait_drain("drain_r4096", 21000);
    stop_run();
    idle(40);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
